// File: rtl/dmem_scan.sv
// dmem_scan: dual-port data memory. Port A is the CPU byte-enable load/store
// port with a registered read. Port B is a scan engine that streams a run of
// consecutive words out over valid/ready through a 2-entry skid buffer.
module dmem_scan #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4096,
  parameter int LEN_W  = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [31:0]              a_adr,
  input  logic                     a_we,
  input  logic [DATA_W/8-1:0]      a_be,
  input  logic [DATA_W-1:0]        a_wd,
  output logic [DATA_W-1:0]        a_rd,
  input  logic                     scan_start,
  input  logic [$clog2(DEPTH)-1:0] scan_base,
  input  logic [LEN_W-1:0]         scan_len,
  output logic                     scan_busy,
  output logic                     scan_valid,
  output logic [DATA_W-1:0]        scan_data,
  output logic                     scan_last,
  input  logic                     scan_ready
);
  localparam int AW = $clog2(DEPTH);
  localparam int NB = DATA_W / 8;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  // Storage; never reset so contents survive a scan abort.
  logic [DATA_W-1:0] mem [DEPTH];

  logic [AW-1:0]     a_idx;
  logic              unused_adr;
  logic [DATA_W-1:0] a_rd_q;

  state_t            state_q, state_d;
  logic [AW-1:0]     ptr_q, ptr_d;
  logic [LEN_W-1:0]  rem_q, rem_d;

  // Entry "b" is the memory read register (holds the newest word); entry
  // "sk" is the skid register (holds the older word when both are full).
  logic [DATA_W-1:0] b_data_q, sk_data_q;
  logic              b_vld_q, sk_vld_q;
  logic              b_last_q, sk_last_q;

  logic              pop, pop_b, pop_sk;
  logic              b_keep, sk_keep;
  logic              issue, sk_load;
  logic              b_vld_d, sk_vld_d;
  logic              head_last;

  // Only the word-index bits of the CPU address are meaningful.
  assign a_idx      = a_adr[AW+1:2];
  assign unused_adr = ^{a_adr[31:AW+2], a_adr[1:0]};

  // Byte-masked CPU write; bytes with a clear enable keep their old value.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NB; i++) begin
      if (a_we && a_be[i]) begin
        mem[a_idx][i*8 +: 8] <= a_wd[i*8 +: 8];
      end
    end
  end

  // Port A registered read; read-first with respect to a same-cycle write.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_rd_q <= '0;
    end else begin
      a_rd_q <= mem[a_idx];
    end
  end

  assign a_rd = a_rd_q;

  // Skid-buffer bookkeeping: what survives this edge and whether a new read
  // fits. The read issued this edge lands in "b", so an occupied "b" that is
  // not being consumed must shift into "sk" to make room.
  assign pop       = scan_valid & scan_ready;
  assign pop_sk    = pop & sk_vld_q;
  assign pop_b     = pop & ~sk_vld_q & b_vld_q;
  assign b_keep    = b_vld_q & ~pop_b;
  assign sk_keep   = sk_vld_q & ~pop_sk;
  assign issue     = (state_q == S_RUN) && (rem_q != '0) && !(b_keep && sk_keep);
  assign sk_load   = issue & b_keep;
  assign b_vld_d   = issue | b_keep;
  assign sk_vld_d  = sk_load | sk_keep;
  assign head_last = sk_vld_q ? sk_last_q : b_last_q;

  // Scan FSM next state: latch parameters on start, walk the pointer per issue,
  // and return to idle once the last-tagged word is accepted.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    rem_d   = rem_q;
    case (state_q)
      S_IDLE: begin
        if (scan_start && (scan_len != '0)) begin
          state_d = S_RUN;
          ptr_d   = scan_base;
          rem_d   = scan_len;
        end
      end
      S_RUN: begin
        if (issue) begin
          ptr_d = ptr_q + 1'b1;
          rem_d = rem_q - 1'b1;
        end
        if (pop && head_last) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Scan FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      rem_q   <= rem_d;
    end
  end

  // Port B read register and skid entry; reset flushes both.
  always_ff @(posedge clk) begin
    if (reset) begin
      b_data_q  <= '0;
      b_last_q  <= 1'b0;
      b_vld_q   <= 1'b0;
      sk_data_q <= '0;
      sk_last_q <= 1'b0;
      sk_vld_q  <= 1'b0;
    end else begin
      b_vld_q  <= b_vld_d;
      sk_vld_q <= sk_vld_d;
      if (issue) begin
        b_data_q <= mem[ptr_q];
        b_last_q <= (rem_q == LEN_W'(1));
      end
      if (sk_load) begin
        sk_data_q <= b_data_q;
        sk_last_q <= b_last_q;
      end
    end
  end

  // The older entry is always presented first.
  assign scan_busy  = (state_q == S_RUN);
  assign scan_valid = b_vld_q | sk_vld_q;
  assign scan_data  = sk_vld_q ? sk_data_q : b_data_q;
  assign scan_last  = scan_valid & head_last;

endmodule

// File: tb/tb_dmem_scan.sv
// Self-checking bench for dmem_scan: CPU port byte writes/reads and scan
// streaming (timing, wrap, backpressure, ignored starts, collision, reset).
module tb_dmem_scan;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 16;
  localparam int LEN_W  = 16;
  localparam int AW     = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [31:0]       a_adr;
  logic              a_we;
  logic [3:0]        a_be;
  logic [31:0]       a_wd;
  logic [31:0]       a_rd;
  logic              scan_start;
  logic [AW-1:0]     scan_base;
  logic [LEN_W-1:0]  scan_len;
  logic              scan_busy;
  logic              scan_valid;
  logic [31:0]       scan_data;
  logic              scan_last;
  logic              scan_ready;

  int checks = 0;
  int errors = 0;

  logic [31:0] model [DEPTH];
  logic [31:0] exp_q [$];
  bit          last_q [$];
  bit          pat [7];

  dmem_scan #(.DATA_W(DATA_W), .DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .a_adr      (a_adr),
    .a_we       (a_we),
    .a_be       (a_be),
    .a_wd       (a_wd),
    .a_rd       (a_rd),
    .scan_start (scan_start),
    .scan_base  (scan_base),
    .scan_len   (scan_len),
    .scan_busy  (scan_busy),
    .scan_valid (scan_valid),
    .scan_data  (scan_data),
    .scan_last  (scan_last),
    .scan_ready (scan_ready)
  );

  always #5 clk = ~clk;

  // Port A write of one word; the model applies the same byte mask.
  task automatic write_word(input int word, input logic [3:0] be, input logic [31:0] d);
    @(negedge clk);
    a_we = 1'b1; a_adr = 32'(word * 4); a_be = be; a_wd = d;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) model[word][i*8 +: 8] = d[i*8 +: 8];
    end
    @(negedge clk);
    a_we = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (a_rd !== 32'h0)    $display("FAIL reset_a_rd got=%h exp=0", a_rd);
    if (a_rd !== 32'h0) errors++;
    checks++; if (scan_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", scan_busy); end
    checks++; if (scan_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", scan_valid); end
    checks++; if (scan_last !== 1'b0) begin errors++; $display("FAIL reset_last got=%b exp=0", scan_last); end
    checks++; if (scan_data !== 32'h0) begin errors++; $display("FAIL reset_data got=%h exp=0", scan_data); end
    reset = 1'b0;
    $display("reset checked");
  endtask

  task automatic test_byte_write();
    write_word(4, 4'hF, 32'hAABBCCDD);
    write_word(4, 4'h5, 32'h11223344);
    @(negedge clk); a_adr = 32'h10;
    @(negedge clk);
    checks++; if (a_rd !== 32'hAA22CC44) begin errors++; $display("FAIL byte_mask got=%h exp=AA22CC44", a_rd); end
    $display("byte write read 0x10 -> %h", a_rd);
    write_word(4, 4'h0, 32'hFFFFFFFF);
    @(negedge clk);
    checks++; if (a_rd !== 32'hAA22CC44) begin errors++; $display("FAIL be0_noop got=%h exp=AA22CC44", a_rd); end
    // Read-first: same-cycle write returns the old word.
    a_we = 1'b1; a_adr = 32'h10; a_be = 4'hF; a_wd = 32'h5555AAAA;
    model[4] = 32'h5555AAAA;
    @(negedge clk);
    a_we = 1'b0;
    checks++; if (a_rd !== 32'hAA22CC44) begin errors++; $display("FAIL a_read_first got=%h exp=AA22CC44", a_rd); end
    @(negedge clk);
    checks++; if (a_rd !== 32'h5555AAAA) begin errors++; $display("FAIL a_after_write got=%h exp=5555AAAA", a_rd); end
    // Upper and lower address bits are ignored.
    a_adr = 32'h8000_0013;
    @(negedge clk);
    checks++; if (a_rd !== 32'h5555AAAA) begin errors++; $display("FAIL a_adr_ignore got=%h exp=5555AAAA", a_rd); end
  endtask

  task automatic preload();
    for (int i = 0; i < DEPTH; i++) write_word(i, 4'hF, 32'h100 + 32'(i));
  endtask

  // Start a scan, push its expected words, then watch the stream.
  task automatic run_scan(input int base, input int len, input bit bp, input bit timing,
                          input bit poke, input int coll);
    int last_hs = 0;
    int first_v = 0;
    int got = 0;
    bit done = 1'b0;
    bit prev_stall = 1'b0;
    logic [31:0] prev_data = '0;
    logic prev_last = 1'b0;
    logic [31:0] ed;
    bit el;
    @(negedge clk);
    scan_start = 1'b1; scan_base = AW'(base); scan_len = LEN_W'(len); scan_ready = 1'b1;
    for (int i = 0; i < len; i++) begin
      exp_q.push_back(model[(base + i) % DEPTH]);
      last_q.push_back(i == len - 1);
    end
    for (int cyc = 1; cyc <= 100 && !done; cyc++) begin
      @(negedge clk);
      scan_start = 1'b0;
      if (poke && cyc == 3) begin
        scan_start = 1'b1; scan_base = '0; scan_len = LEN_W'(2);
      end
      if (coll >= 0) begin
        if (cyc == 1) begin
          a_we = 1'b1; a_adr = 32'(coll * 4); a_be = 4'hF; a_wd = 32'hDEAD0000 | 32'(coll);
          model[coll] = a_wd;
        end else begin
          a_we = 1'b0;
        end
      end
      scan_ready = (bp && cyc >= 2 && cyc - 2 < 7) ? pat[cyc-2] : 1'b1;
      if (cyc == 1) begin
        checks++; if (scan_valid !== 1'b0) begin errors++; $display("FAIL early_valid got=%b exp=0", scan_valid); end
      end
      if (last_hs != 0) begin
        checks++;
        if (scan_busy !== 1'b0 || scan_valid !== 1'b0) begin
          errors++; $display("FAIL end_idle busy=%b valid=%b exp=0/0", scan_busy, scan_valid);
        end
        done = 1'b1;
      end else begin
        checks++; if (scan_busy !== 1'b1) begin errors++; $display("FAIL busy_hold cyc=%0d got=%b exp=1", cyc, scan_busy); end
        if (prev_stall) begin
          checks++;
          if (scan_valid !== 1'b1 || scan_data !== prev_data || scan_last !== prev_last) begin
            errors++; $display("FAIL stall_stable valid=%b data=%h last=%b exp=1/%h/%b",
                               scan_valid, scan_data, scan_last, prev_data, prev_last);
          end
        end
        if (scan_valid === 1'b1 && first_v == 0) first_v = cyc;
        if (scan_valid === 1'b1 && scan_ready) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++; $display("FAIL extra_word got=%h exp=none", scan_data);
          end else begin
            ed = exp_q.pop_front(); el = last_q.pop_front();
            got++;
            if (scan_data !== ed || scan_last !== el) begin
              errors++; $display("FAIL scan_word got=%h/%b exp=%h/%b", scan_data, scan_last, ed, el);
            end
            $display("scan base=%0d cyc=%0d data=%h last=%b", base, cyc, scan_data, scan_last);
            if (el) last_hs = cyc;
          end
        end
        prev_stall = (scan_valid === 1'b1) && !scan_ready;
        prev_data  = scan_data;
        prev_last  = scan_last;
      end
    end
    a_we = 1'b0;
    checks++; if (!done) begin errors++; $display("FAIL scan_timeout got=%0d words exp=%0d", got, len); end
    checks++; if (got != len || exp_q.size() != 0) begin
      errors++; $display("FAIL word_count got=%0d exp=%0d", got, len);
    end
    if (timing) begin
      checks++; if (first_v != 2) begin errors++; $display("FAIL first_valid got=%0d exp=2", first_v); end
      checks++; if (last_hs != len + 1) begin errors++; $display("FAIL last_hs got=%0d exp=%0d", last_hs, len + 1); end
    end
    exp_q.delete(); last_q.delete();
  endtask

  task automatic test_basic_scan();
    run_scan(2, 4, 1'b0, 1'b1, 1'b0, -1);
  endtask

  task automatic test_wrap();
    run_scan(14, 4, 1'b0, 1'b1, 1'b0, -1);
  endtask

  task automatic test_backpressure();
    run_scan(3, 6, 1'b1, 1'b0, 1'b0, -1);
  endtask

  task automatic test_edge_starts();
    @(negedge clk);
    scan_start = 1'b1; scan_base = AW'(3); scan_len = '0;
    @(negedge clk);
    scan_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (scan_busy !== 1'b0 || scan_valid !== 1'b0) begin
        errors++; $display("FAIL len0_ignored busy=%b valid=%b exp=0/0", scan_busy, scan_valid);
      end
      @(negedge clk);
    end
    run_scan(8, 5, 1'b0, 1'b1, 1'b1, -1);
  endtask

  task automatic test_collision();
    run_scan(5, 1, 1'b0, 1'b1, 1'b0, 5);
    @(negedge clk); a_adr = 32'h14;
    @(negedge clk);
    checks++; if (a_rd !== 32'hDEAD0005) begin errors++; $display("FAIL coll_written got=%h exp=DEAD0005", a_rd); end
  endtask

  task automatic test_reset_mid_scan();
    @(negedge clk);
    scan_start = 1'b1; scan_base = '0; scan_len = LEN_W'(10); scan_ready = 1'b1;
    @(negedge clk);
    scan_start = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (scan_valid !== 1'b1) begin errors++; $display("FAIL pre_reset_valid got=%b exp=1", scan_valid); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++; if (scan_busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", scan_busy); end
    checks++; if (scan_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b exp=0", scan_valid); end
    checks++; if (scan_last !== 1'b0) begin errors++; $display("FAIL rst_last got=%b exp=0", scan_last); end
    @(negedge clk);
    checks++; if (scan_valid !== 1'b0 || scan_busy !== 1'b0) begin
      errors++; $display("FAIL rst_stay_idle busy=%b valid=%b exp=0/0", scan_busy, scan_valid);
    end
    a_adr = 32'h14;
    @(negedge clk);
    checks++; if (a_rd !== model[5]) begin errors++; $display("FAIL rst_mem5 got=%h exp=%h", a_rd, model[5]); end
    a_adr = 32'h24;
    @(negedge clk);
    checks++; if (a_rd !== model[9]) begin errors++; $display("FAIL rst_mem9 got=%h exp=%h", a_rd, model[9]); end
  endtask

  task automatic test_back_to_back();
    run_scan(0, 3, 1'b0, 1'b1, 1'b0, -1);
    run_scan(13, 5, 1'b0, 1'b1, 1'b0, -1);
  endtask

  initial begin
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
    pat[4] = 1'b0; pat[5] = 1'b1; pat[6] = 1'b1;
    reset = 1'b1; a_adr = '0; a_we = 1'b0; a_be = '0; a_wd = '0;
    scan_start = 1'b0; scan_base = '0; scan_len = '0; scan_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    test_reset();
    test_byte_write();
    preload();
    test_basic_scan();
    test_wrap();
    test_backpressure();
    test_edge_starts();
    test_collision();
    test_reset_mid_scan();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
